// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W = 32;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_D = 2'b01,
    BUSY_I = 2'b10
  } state_t;
endpackage

// File: rtl/arb_perf_counter.sv
// arb_perf_counter: saturating up-counter with enable
//   clk, reset (async, active-high), en: count this edge; count: current value
module arb_perf_counter
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (en && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between IF and MEM stages
//   clk, reset (async, active-high)
//   if_req/if_addr -> if_rdata           instruction fetch side
//   d_read/d_write/d_addr/d_wdata -> d_rdata   data access side
//   stall                                 global pipeline freeze (combinational)
//   m_req/m_we/m_addr/m_wdata, m_ready/m_rdata   memory handshake
//   stall_cycles                          stall counter, live only with ARB_PERF_CNT_EN
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  stall_cycles
);
  state_t state;
  logic d_done, i_done;
  logic d_need;
  assign d_need = d_read | d_write;
  assign stall = (d_need & ~d_done) | (if_req & ~i_done);
  // Done flags only clear on an unstalled edge, which cannot coincide with a completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
      i_done   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (d_need && !d_done) begin
            state   <= BUSY_D;
            m_req   <= 1'b1;
            m_we    <= d_write;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (if_req && !i_done) begin
            state  <= BUSY_I;
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= if_addr;
          end
        BUSY_D:
          if (m_ready) begin
            state  <= IDLE;
            m_req  <= 1'b0;
            d_done <= 1'b1;
            if (d_read) d_rdata <= m_rdata;
          end
        BUSY_I:
          if (m_ready) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            i_done   <= 1'b1;
            if_rdata <= m_rdata;
          end
        default: state <= IDLE;
      endcase
      if (!stall) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end
    end
  end
`ifdef ARB_PERF_CNT_EN
  arb_perf_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (stall),
    .count(stall_cycles)
  );
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between two pipeline users: the instruction fetch (IF) stage and the data access (MEM) stage of the 5-stage RV32I core.
- Serialises their accesses through a request/ready handshake to the memory.
- Holds each completed result until the pipeline advances.
- Produces one global stall that the top level uses to freeze the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  IF stage needs the instruction at if_addr.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction, registered.
- d_read  in  1  MEM stage load request.
- d_write  in  1  MEM stage store request; never asserted together with d_read.
- d_addr  in  ADDR_W  data address (ALU result).
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- stall  out  1  global pipeline freeze.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write enable, registered.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data, registered.
- m_ready  in  1  memory completes the current request this cycle.
- m_rdata  in  DATA_W  memory read data, valid when m_ready=1.
- stall_cycles  out  32  performance counter; see Optional Feature.

Behaviour:
- Reset (async, active-high): state=IDLE; m_req, m_we, m_addr, m_wdata, if_rdata, d_rdata, d_done, i_done all 0.
- Internal signals: d_need = d_read|d_write. Flags d_done and i_done mark a result already obtained for the current pipeline cycle.
- stall is combinational: (d_need & ~d_done) | (if_req & ~i_done).
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE, data first: if d_need & ~d_done, go to BUSY_D; register m_req=1, m_we=d_write, m_addr=d_addr, m_wdata=d_wdata.
- IDLE, fetch second: else if if_req & ~i_done, go to BUSY_I; register m_req=1, m_we=0, m_addr=if_addr.
- Data has fixed priority over fetch (older instruction first). Starvation of IF is impossible: while stall=1 the pipeline is frozen, so no new data request can appear.
- BUSY_x: m_req, m_we, m_addr, m_wdata are held stable until m_ready=1.
- On the edge where m_ready=1: m_req drops to 0 and state returns to IDLE.
  - BUSY_D: d_done set; on a load, d_rdata latches m_rdata; on a store, d_rdata is unchanged.
  - BUSY_I: i_done set; if_rdata latches m_rdata.
- Pipeline advance: on any edge where stall=0, d_done and i_done both clear. if_rdata and d_rdata keep their values until overwritten.
- Latency with m_ready tied high:
  - Fetch only: stall=1 for 2 cycles (IDLE, BUSY_I), 0 in the 3rd.
  - Load plus fetch: stall=1 for 4 cycles, 0 in the 5th.
  - No request: stall=0, FSM stays in IDLE.
- While stall=1, requesters hold if_addr, d_addr, d_wdata, d_read and d_write stable. The arbiter does not re-check them mid-transaction.
- m_ready=1 outside BUSY_x: ignored.
- Reset asserted mid-transaction: m_req drops immediately; the memory must treat that as an abort.
- No request is issued in the same cycle as the m_ready of the previous one. Back-to-back requests have ≥1 IDLE cycle between them.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: stall_cycles increments on each edge with stall=1 and saturates at 0xFFFFFFFF. Reset value 0.
- Undefined: stall_cycles tied to 0 and no counter logic is synthesised. The port remains so instantiations do not change.

Decomposition:
- Shared package (mem_arb_pkg):
  - FSM state enum (IDLE=2'b00, BUSY_D=2'b01, BUSY_I=2'b10).
  - ADDR_W/DATA_W defaults.
  - Counter width constant (32).
- One natural sub-module: arb_perf_counter, a saturating counter with enable. It is instantiated only under ARB_PERF_CNT_EN.

Test Plan:
- Reset, then fetch with m_ready=1 immediately, if_addr=0x0000_0004, m_rdata=0x0020_8093 → m_req=1 with m_addr=0x4 and m_we=0 in cycle 1; if_rdata=0x0020_8093 and stall=0 in cycle 2.
- Simultaneous if_req (addr 0x10) and d_read (addr 0x30) with m_ready=1 → first m_addr=0x30, then m_addr=0x10; stall=1 for 4 cycles; d_rdata and if_rdata hold their respective m_rdata values.
- d_write, d_addr=0x0C, d_wdata=0xDEAD_BEEF, m_ready delayed 3 cycles → m_req, m_we=1, m_addr and m_wdata held stable for all 3 wait cycles; d_rdata unchanged; stall drops only after completion.
- Assert reset during BUSY_I with m_ready=0 → m_req=0, if_rdata=0 and stall reflects if_req with FSM in IDLE, all without waiting for a clock edge.
- With ARB_PERF_CNT_EN, load plus fetch with m_ready=1 → stall_cycles=4. Without the macro → stall_cycles=0.
- Two consecutive advances (stall=0 edges) with only if_req → d_done and i_done clear on each advance; a new fetch is issued for each new if_addr.
